vga_pixel_pipe: RTL and testbench

//  Downstream of the VGA sync/count stage. Consumes hsync/vsync, Hdisplay/Vdisplay and the hrow/vcolumn pixel coordinates.

---
 rtl/vga_pixel_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_pipe.sv
// Pixel stage behind the VGA timing generator: picks framebuffer or pattern colour per pixel
// and delays sync/display-enable so that all outputs leave together on the colour's cycle.
module vga_pixel_pipe #(
  parameter int READ_LAT    = 1,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15
) (
  input  logic              inputclk,
  input  logic              reset_b,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              Hdisplay,
  input  logic              Vdisplay,
  input  logic [9:0]        hrow,
  input  logic [9:0]        vcolumn,
  input  logic [1:0]        mode_req,
  input  logic [11:0]       solid_rgb,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  input  logic [11:0]       fb_data,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              de_out,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [7:0]        frame_count,
  output logic [1:0]        mode_active
);

  typedef enum logic [1:0] {
    MODE_FB    = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_GRID  = 2'd3
  } mode_e;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        vis;
    logic        isFb;
    logic [11:0] pat;
  } pixStage_t;

  localparam int        FbWidth    = 640 >> SCALE_SHIFT;
  localparam pixStage_t StageReset = '{hs: 1'b1, vs: 1'b1, de: 1'b0, vis: 1'b0,
                                       isFb: 1'b0, pat: 12'h000};

  logic              vsyncPrev_q;
  mode_e             modeActive_q;
  logic [7:0]        frameCount_q;
  logic              frameStart;
  mode_e             modeEff;
  logic [7:0]        frameCountEff;

  logic              pixelDe;
  logic              inRange;
  logic [4:0]        gridX;
  logic [11:0]       barColour;
  logic [11:0]       gridColour;
  logic [11:0]       patColour;
  logic              fbRdEn_d;
  logic              fbRdEn_q;
  logic [ADDR_W-1:0] fbAddr_d;
  logic [ADDR_W-1:0] fbAddr_q;
  pixStage_t         stageA_d;
  pixStage_t         stageA_q;
  pixStage_t         dly_q [READ_LAT];

  logic              hsync_q;
  logic              vsync_q;
  logic              de_q;
  logic [11:0]       rgb_d;
  logic [11:0]       rgb_q;

  // A frame start on the same cycle as a pixel already applies the new mode and count to it.
  assign frameStart    = vsync_in & ~vsyncPrev_q;
  assign modeEff       = frameStart ? mode_e'(mode_req) : modeActive_q;
  assign frameCountEff = frameStart ? frameCount_q + 8'd1 : frameCount_q;

  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      vsyncPrev_q  <= 1'b1;
      modeActive_q <= MODE_FB;
      frameCount_q <= 8'd0;
    end else begin
      vsyncPrev_q  <= vsync_in;
      modeActive_q <= modeEff;
      frameCount_q <= frameCountEff;
    end
  end

  assign pixelDe = Hdisplay & Vdisplay;
  assign inRange = (hrow < 10'd640) && (vcolumn < 10'd480);

  always_comb begin
    barColour = 12'h000;
    if (hrow < 10'd80) begin
      barColour = 12'hFFF;
    end else if (hrow < 10'd160) begin
      barColour = 12'hFF0;
    end else if (hrow < 10'd240) begin
      barColour = 12'h0FF;
    end else if (hrow < 10'd320) begin
      barColour = 12'h0F0;
    end else if (hrow < 10'd400) begin
      barColour = 12'hF0F;
    end else if (hrow < 10'd480) begin
      barColour = 12'hF00;
    end else if (hrow < 10'd560) begin
      barColour = 12'h00F;
    end
  end

  // Only the low five bits of (hrow + frame_count) decide a grid line, so a 5-bit add suffices.
  assign gridX      = hrow[4:0] + frameCountEff[4:0];
  assign gridColour = ((gridX == 5'd0) || (vcolumn[4:0] == 5'd0)) ? 12'hFFF : 12'h000;

  always_comb begin
    patColour = 12'h000;
    case (modeEff)
      MODE_BARS:  patColour = barColour;
      MODE_SOLID: patColour = solid_rgb;
      MODE_GRID:  patColour = gridColour;
      default:    patColour = 12'h000;
    endcase
  end

  assign fbRdEn_d = pixelDe && (modeEff == MODE_FB);
  assign fbAddr_d = ADDR_W'((32'(vcolumn) >> SCALE_SHIFT) * FbWidth
                            + (32'(hrow) >> SCALE_SHIFT));

  always_comb begin
    stageA_d      = StageReset;
    stageA_d.hs   = hsync_in;
    stageA_d.vs   = vsync_in;
    stageA_d.de   = pixelDe;
    stageA_d.vis  = pixelDe & inRange;
    stageA_d.isFb = (modeEff == MODE_FB);
    stageA_d.pat  = patColour;
  end

  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      fbRdEn_q <= 1'b0;
      fbAddr_q <= '0;
      stageA_q <= StageReset;
    end else begin
      fbRdEn_q <= fbRdEn_d;
      if (fbRdEn_d) begin
        fbAddr_q <= fbAddr_d;
      end
      stageA_q <= stageA_d;
    end
  end

  // Sideband waits here while the framebuffer read is in flight.
  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < READ_LAT; i++) begin
        dly_q[i] <= StageReset;
      end
    end else begin
      dly_q[0] <= stageA_q;
      for (int i = 1; i < READ_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  always_comb begin
    rgb_d = 12'h000;
    if (dly_q[READ_LAT-1].vis) begin
      rgb_d = dly_q[READ_LAT-1].isFb ? fb_data : dly_q[READ_LAT-1].pat;
    end
  end

  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= 12'h000;
    end else begin
      hsync_q <= dly_q[READ_LAT-1].hs;
      vsync_q <= dly_q[READ_LAT-1].vs;
      de_q    <= dly_q[READ_LAT-1].de;
      rgb_q   <= rgb_d;
    end
  end

  assign fb_addr     = fbAddr_q;
  assign fb_rd_en    = fbRdEn_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign de_out      = de_q;
  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign frame_count = frameCount_q;
  assign mode_active = modeActive_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe with a one-cycle synchronous framebuffer model.
module tb_vga_pixel_pipe;

  logic        inputclk = 1'b0;
  logic        reset_b;
  logic        hsync_in, vsync_in, Hdisplay, Vdisplay;
  logic [9:0]  hrow, vcolumn;
  logic [1:0]  mode_req;
  logic [11:0] solid_rgb;
  logic [14:0] fb_addr;
  logic        fb_rd_en;
  logic [11:0] fb_data = 12'h000;
  logic        hsync_out, vsync_out, de_out;
  logic [3:0]  red, green, blue;
  logic [7:0]  frame_count;
  logic [1:0]  mode_active;

  int totalChecks = 0;
  int badChecks   = 0;
  int expFrames   = 0;
  int fc;
  logic [9:0] x0;

  vga_pixel_pipe #(.READ_LAT(1), .SCALE_SHIFT(2), .ADDR_W(15)) dut (
    .inputclk(inputclk), .reset_b(reset_b),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .Hdisplay(Hdisplay), .Vdisplay(Vdisplay),
    .hrow(hrow), .vcolumn(vcolumn),
    .mode_req(mode_req), .solid_rgb(solid_rgb),
    .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_data(fb_data),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .red(red), .green(green), .blue(blue),
    .frame_count(frame_count), .mode_active(mode_active)
  );

  always #5 inputclk = ~inputclk;

  function automatic logic [11:0] fbContent(input logic [14:0] a);
    if (a == 15'd321) return 12'hABC;
    return 12'(a ^ 15'h05A5);
  endfunction

  always @(posedge inputclk) begin
    if (fb_rd_en) fb_data <= fbContent(fb_addr);
  end

  function automatic logic [14:0] fbAddrOf(input int x, input int y);
    return 15'((y >> 2) * 160 + (x >> 2));
  endfunction

  function automatic logic [11:0] gridExpect(input int x, input int y, input int f);
    return ((((x + f) % 1024) % 32) == 0 || (y % 32) == 0) ? 12'hFFF : 12'h000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic hs, input logic vs, input logic hd, input logic vd,
                               input logic [9:0] x, input logic [9:0] y);
    hsync_in = hs;
    vsync_in = vs;
    Hdisplay = hd;
    Vdisplay = vd;
    hrow     = x;
    vcolumn  = y;
    @(posedge inputclk);
    #1;
  endtask

  task automatic idleStep();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
  endtask

  task automatic pulseVsync();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    expFrames++;
  endtask

  task automatic checkPixel(input string tag, input logic hd, input logic vd,
                            input logic [9:0] x, input logic [9:0] y, input logic [11:0] expRgb);
    applyStimulus(1'b1, 1'b1, hd, vd, x, y);
    idleStep();
    checkOutput({tag, "_early"}, {19'd0, de_out, red, green, blue}, 32'd0);
    idleStep();
    checkOutput({tag, "_de"}, {31'd0, de_out}, {31'd0, hd & vd});
    checkOutput({tag, "_rgb"}, {20'd0, red, green, blue}, {20'd0, expRgb});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_hs"}, {31'd0, hsync_out}, 32'd1);
    checkOutput({tag, "_vs"}, {31'd0, vsync_out}, 32'd1);
    checkOutput({tag, "_de"}, {31'd0, de_out}, 32'd0);
    checkOutput({tag, "_rgb"}, {20'd0, red, green, blue}, 32'd0);
    checkOutput({tag, "_rden"}, {31'd0, fb_rd_en}, 32'd0);
    checkOutput({tag, "_addr"}, {17'd0, fb_addr}, 32'd0);
    checkOutput({tag, "_fc"}, {24'd0, frame_count}, 32'd0);
    checkOutput({tag, "_mode"}, {30'd0, mode_active}, 32'd0);
  endtask

  initial begin
    reset_b   = 1'b0;
    mode_req  = 2'd0;
    solid_rgb = 12'h000;
    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      mode_req  = 2'($urandom_range(0, 3));
      solid_rgb = 12'($urandom);
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
    end
    checkResetState("rst");
    mode_req  = 2'd0;
    solid_rgb = 12'h3C7;
    idleStep();
    reset_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idleStep();
      checkOutput("postRel", {19'd0, de_out, red, green, blue}, 32'd0);
    end

    // Framebuffer read path and sync alignment
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'd4, 10'd8);
    checkOutput("fbAddr", {17'd0, fb_addr}, 32'd321);
    checkOutput("fbRdEn", {31'd0, fb_rd_en}, 32'd1);
    checkOutput("fcBefore", {24'd0, frame_count}, 32'd0);
    idleStep();
    expFrames++;
    checkOutput("rdEnLow", {31'd0, fb_rd_en}, 32'd0);
    checkOutput("addrHold", {17'd0, fb_addr}, 32'd321);
    checkOutput("hsEarly", {31'd0, hsync_out}, 32'd1);
    idleStep();
    checkOutput("fbDe", {31'd0, de_out}, 32'd1);
    checkOutput("fbRgb", {20'd0, red, green, blue}, 32'hABC);
    checkOutput("hsDly", {31'd0, hsync_out}, 32'd0);
    checkOutput("vsDly", {31'd0, vsync_out}, 32'd0);
    checkOutput("fcAfter", {24'd0, frame_count}, 32'd1);
    idleStep();
    checkOutput("hsBack", {31'd0, hsync_out}, 32'd1);
    checkOutput("deBack", {31'd0, de_out}, 32'd0);

    // Colour bars
    mode_req = 2'd1;
    pulseVsync();
    checkOutput("modeBars", {30'd0, mode_active}, 32'd1);
    checkOutput("fcBars", {24'd0, frame_count}, 32'(expFrames));
    checkPixel("bar79", 1'b1, 1'b1, 10'd79, 10'd10, 12'hFFF);
    checkPixel("bar80", 1'b1, 1'b1, 10'd80, 10'd10, 12'hFF0);
    checkPixel("bar160", 1'b1, 1'b1, 10'd160, 10'd10, 12'h0FF);
    checkPixel("bar320", 1'b1, 1'b1, 10'd320, 10'd10, 12'hF0F);
    checkPixel("bar400", 1'b1, 1'b1, 10'd400, 10'd10, 12'hF00);
    checkPixel("bar559", 1'b1, 1'b1, 10'd559, 10'd10, 12'h00F);
    checkPixel("bar639", 1'b1, 1'b1, 10'd639, 10'd10, 12'h000);

    // Mode request held off until the next frame start
    mode_req = 2'd0;
    pulseVsync();
    checkOutput("modeFb", {30'd0, mode_active}, 32'd0);
    mode_req = 2'd2;
    idleStep();
    checkPixel("fbPending", 1'b1, 1'b1, 10'd200, 10'd100, fbContent(fbAddrOf(200, 100)));
    checkOutput("modeHeld", {30'd0, mode_active}, 32'd0);
    pulseVsync();
    checkOutput("modeSolid", {30'd0, mode_active}, 32'd2);
    checkPixel("solid", 1'b1, 1'b1, 10'd10, 10'd20, 12'h3C7);
    checkPixel("blankDe", 1'b1, 1'b0, 10'd10, 10'd20, 12'h000);
    checkPixel("blankX", 1'b1, 1'b1, 10'd700, 10'd20, 12'h000);
    checkPixel("blankY", 1'b1, 1'b1, 10'd10, 10'd480, 12'h000);

    // Frame start coinciding with a visible pixel
    mode_req = 2'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'd100, 10'd20);
    expFrames++;
    checkOutput("sameMode", {30'd0, mode_active}, 32'd1);
    idleStep();
    idleStep();
    checkOutput("sameDe", {31'd0, de_out}, 32'd1);
    checkOutput("sameRgb", {20'd0, red, green, blue}, 32'hFF0);

    // Frame counter wrap and grid scrolling
    mode_req = 2'd3;
    for (int i = 0; i < 256; i++) begin
      pulseVsync();
      checkOutput("fcStep", {24'd0, frame_count}, 32'(expFrames % 256));
    end
    checkOutput("modeGrid", {30'd0, mode_active}, 32'd3);
    fc = expFrames % 256;
    x0 = 10'(64 + ((32 - (fc % 32)) % 32));
    checkPixel("gridLine", 1'b1, 1'b1, x0, 10'd10, 12'hFFF);
    checkPixel("gridGap", 1'b1, 1'b1, x0 + 10'd1, 10'd10, gridExpect(int'(x0) + 1, 10, fc));
    pulseVsync();
    fc = expFrames % 256;
    checkPixel("gridShift", 1'b1, 1'b1, x0 - 10'd1, 10'd10, 12'hFFF);
    checkPixel("gridOld", 1'b1, 1'b1, x0, 10'd10, gridExpect(int'(x0), 10, fc));
    checkPixel("gridRow", 1'b1, 1'b1, x0 + 10'd3, 10'd64, 12'hFFF);

    // Reset in the middle of a visible line
    mode_req = 2'd0;
    pulseVsync();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'd200, 10'd100);
    idleStep();
    #2;
    reset_b = 1'b0;
    #1;
    checkResetState("midRst");
    expFrames = 0;
    @(posedge inputclk);
    #1;
    reset_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idleStep();
      checkOutput("noStale", {19'd0, de_out, red, green, blue}, 32'd0);
    end
    checkPixel("afterRst", 1'b1, 1'b1, 10'd4, 10'd8, 12'hABC);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
